// File: rtl/spi_master_reg.sv
// SPI mode-0 master for a two-phase register slave: address byte window, then data byte window.
// SS, SCLK and MOSI are decoded from the FSM state and clk-rate counters; no derived clock.
module spi_master_reg #(
  parameter int HALF  = 4,
  parameter int SETUP = 8,
  parameter int GAP   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SS
);
  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} state_t;

  localparam logic [15:0] LEAD_LAST = 16'(SETUP - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP - 2);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg;
  logic [3:0]  half_reg;
  logic        phase_reg;  // 0: address byte window, 1: data byte window
  logic        rw_reg;
  logic [1:0]  addr_reg;
  logic [7:0]  wdata_reg;
  logic [7:0]  rx_reg;
  logic [7:0]  rdata_reg;
  logic        cnt_last;
  logic [7:0]  cur_byte;

  always_comb begin
    cnt_last = 1'b0;
    case (state_reg)
      S_LEAD:           cnt_last = (cnt_reg == LEAD_LAST);
      S_SHIFT, S_TRAIL: cnt_last = (cnt_reg == HALF_LAST);
      S_GAP:            cnt_last = (cnt_reg == GAP_LAST);
      default:          cnt_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_LEAD;
      S_LEAD:  if (cnt_last) state_next = S_SHIFT;
      S_SHIFT: if (cnt_last && half_reg == 4'd15) state_next = S_TRAIL;
      S_TRAIL: if (cnt_last) state_next = S_GAP;
      S_GAP:   if (cnt_last) state_next = phase_reg ? S_IDLE : S_LEAD;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg   <= '0;
      half_reg  <= '0;
      phase_reg <= 1'b0;
      rw_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rx_reg    <= '0;
      rdata_reg <= '0;
    end else begin
      cnt_reg <= (state_reg == S_IDLE || cnt_last) ? '0 : cnt_reg + 16'd1;
      if (state_reg != S_SHIFT) half_reg <= '0;
      else if (cnt_last)        half_reg <= half_reg + 4'd1;
      if (state_reg == S_IDLE) begin
        phase_reg <= 1'b0;
        if (start) begin
          rw_reg    <= rw;
          addr_reg  <= addr;
          wdata_reg <= wdata;
        end
      end else if (state_reg == S_GAP && cnt_last) begin
        phase_reg <= 1'b1;
      end
      // End of an SCLK low half is the rising transition
      if (state_reg == S_SHIFT && cnt_last && !half_reg[0]) rx_reg <= {rx_reg[6:0], MISO};
      // Loaded one cycle early so rdata is already valid while done is high
      if (state_reg == S_GAP && phase_reg && !rw_reg && cnt_reg == GAP_LOAD) rdata_reg <= rx_reg;
    end
  end

  always_comb begin
    cur_byte = phase_reg ? (rw_reg ? wdata_reg : 8'h00) : {rw_reg, 5'b0, addr_reg};
    SS   = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    done = 1'b0;
    busy = (state_reg != S_IDLE);
    case (state_reg)
      S_LEAD: begin
        SS   = 1'b0;
        MOSI = cur_byte[7];
      end
      S_SHIFT: begin
        SS   = 1'b0;
        SCLK = half_reg[0];
        MOSI = cur_byte[3'd7 - half_reg[3:1]];
      end
      S_TRAIL: SS = 1'b0;
      S_GAP:   done = phase_reg && cnt_last;
      default: ;
    endcase
  end

  assign rdata = rdata_reg;

endmodule

// File: tb/tb_spi_master_reg.sv
// Directed bench: three masters (default, HALF=4 and HALF=6 with SETUP=4/GAP=3), each against
// a behavioural two-phase register slave.
`timescale 1ns/1ps
module tb_spi_master_reg;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] start_v, rw_v, busy_v, done_v, sclk_v, mosi_v, ss_v;
  logic [1:0] addr_v  [3];
  logic [7:0] wdata_v [3];
  logic [7:0] rdata_v [3];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int busy0;
    int ss0;
    int n_done;
    int done_c;
    int ss_bad;
    int sclk_bad;
    int busy_bad;
    logic [7:0] mo_a;
    logic [7:0] mo_d;
    logic [7:0] rd;
  } res_t;

  always #5 clk = ~clk;

  function automatic int hcfg(input int i); return (i == 2) ? 6 : 4; endfunction
  function automatic int scfg(input int i); return (i == 0) ? 8 : 4; endfunction
  function automatic int gcfg(input int i); return (i == 0) ? 8 : 3; endfunction
  function automatic int pcfg(input int i); return scfg(i) + 17 * hcfg(i) + gcfg(i); endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int H = (gi == 2) ? 6 : 4;
    localparam int S = (gi == 0) ? 8 : 4;
    localparam int G = (gi == 0) ? 8 : 3;
    logic       miso    = 1'b0;
    logic       ss_q    = 1'b1;
    logic       sclk_q  = 1'b0;
    logic       ph_data = 1'b0;
    logic       wr_flag = 1'b0;
    logic [1:0] a       = 2'd0;
    logic [7:0] sh_in   = 8'h00;
    logic [7:0] sh_out  = 8'h00;
    int         nbits   = 0;
    logic [7:0] regs [4] = '{default: 8'h00};

    spi_master_reg #(.HALF(H), .SETUP(S), .GAP(G)) u_dut (
      .clk   (clk),
      .reset (reset_n),
      .start (start_v[gi]),
      .rw    (rw_v[gi]),
      .addr  (addr_v[gi]),
      .wdata (wdata_v[gi]),
      .busy  (busy_v[gi]),
      .done  (done_v[gi]),
      .rdata (rdata_v[gi]),
      .SCLK  (sclk_v[gi]),
      .MOSI  (mosi_v[gi]),
      .MISO  (miso),
      .SS    (ss_v[gi])
    );

    // Slave: a window with 8 bits completes a phase; a short window resyncs to the address phase
    always @(posedge clk) begin
      ss_q   <= ss_v[gi];
      sclk_q <= sclk_v[gi];
      if (ss_q && !ss_v[gi]) begin
        nbits  <= 0;
        sh_out <= (ph_data && !wr_flag) ? regs[a] : 8'h00;
        miso   <= ph_data && !wr_flag && regs[a][7];
      end else if (!ss_q && ss_v[gi]) begin
        if (nbits == 8) begin
          if (!ph_data) begin
            ph_data <= 1'b1;
            wr_flag <= sh_in[7];
            a       <= sh_in[1:0];
          end else begin
            ph_data <= 1'b0;
            if (wr_flag) regs[a] <= sh_in;
          end
        end else begin
          ph_data <= 1'b0;
        end
      end else if (!ss_v[gi] && sclk_v[gi] && !sclk_q) begin
        sh_in <= {sh_in[6:0], mosi_v[gi]};
        nbits <= nbits + 1;
      end else if (!ss_v[gi] && !sclk_v[gi] && sclk_q) begin
        sh_out <= {sh_out[6:0], 1'b0};
        miso   <= sh_out[6];
      end
    end
  end

  // Accept at cycle 0, then observe cycles 1..2P against the expected pin timing.
  task automatic run_txn(input int i, input logic w, input logic [1:0] ad, input logic [7:0] wd,
                         input int x1, input int x2, output res_t r);
    int h, s, p, l, o;
    logic exp_ss, exp_sclk;
    h = hcfg(i);
    s = scfg(i);
    p = pcfg(i);
    l = s + 17 * h;
    @(negedge clk);
    r.busy0 = int'(busy_v[i]);
    r.ss0   = int'(ss_v[i]);
    start_v[i] = 1'b1;
    rw_v[i]    = w;
    addr_v[i]  = ad;
    wdata_v[i] = wd;
    r.n_done = 0; r.done_c = -1; r.ss_bad = 0; r.sclk_bad = 0; r.busy_bad = 0;
    r.mo_a = 8'h00; r.mo_d = 8'h00; r.rd = 8'hxx;
    for (int c = 1; c <= 2 * p; c++) begin
      @(negedge clk);
      start_v[i] = (c == x1 || c == x2);
      if (start_v[i]) begin
        rw_v[i]    = 1'b1;
        addr_v[i]  = 2'd0;
        wdata_v[i] = 8'hEE;
      end
      o = (c > p) ? c - p - 1 : c - 1;
      exp_ss   = !(o < l);
      exp_sclk = (o >= s) && (o < s + 16 * h) && ((((o - s) / h) % 2) == 1);
      if (ss_v[i] !== exp_ss) r.ss_bad++;
      if (sclk_v[i] !== exp_sclk) r.sclk_bad++;
      if (busy_v[i] !== 1'b1) r.busy_bad++;
      if ((o >= s) && (o < s + 16 * h) && (((o - s) % (2 * h)) == h)) begin
        if (c > p) r.mo_d = {r.mo_d[6:0], mosi_v[i]};
        else       r.mo_a = {r.mo_a[6:0], mosi_v[i]};
      end
      if (done_v[i] === 1'b1) begin
        r.n_done++;
        r.done_c = c;
        r.rd = rdata_v[i];
      end
    end
    $display("txn dut%0d rw=%0d addr=%0d wdata=%02h mosi=%02h/%02h done=%0d@%0d rdata=%02h",
             i, w, ad, wd, r.mo_a, r.mo_d, r.n_done, r.done_c, r.rd);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start_v = '0;
    rw_v    = '0;
    for (int k = 0; k < 3; k++) begin
      addr_v[k]  = 2'd0;
      wdata_v[k] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({ss_v[i], sclk_v[i], mosi_v[i], busy_v[i], done_v[i]} !== 5'b10000) begin
        n_err++;
        $display("FAIL reset_pins dut%0d: ss/sclk/mosi/busy/done got %b%b%b%b%b, want 10000",
                 i, ss_v[i], sclk_v[i], mosi_v[i], busy_v[i], done_v[i]);
      end
      n_vec++;
      if (rdata_v[i] !== 8'h00) begin
        n_err++;
        $display("FAIL reset_rdata dut%0d: got %02h, want 00", i, rdata_v[i]);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    res_t r;
    logic [7:0] wd;
    for (int k = 0; k < 2; k++) begin
      wd = (k == 0) ? 8'h34 : 8'h12;
      run_txn(0, 1'b1, 2'(k), wd, 0, 0, r);
      n_vec++;
      if (r.n_done !== 1 || r.done_c !== 168 || r.ss_bad !== 0 || r.sclk_bad !== 0 || r.busy_bad !== 0) begin
        n_err++;
        $display("FAIL write_timing reg%0d: done=%0d@%0d ss_bad=%0d sclk_bad=%0d busy_bad=%0d, want done=1@168 bad=0",
                 k, r.n_done, r.done_c, r.ss_bad, r.sclk_bad, r.busy_bad);
      end
      n_vec++;
      if ({r.mo_a, r.mo_d} !== {6'b100000, 2'(k), wd}) begin
        n_err++;
        $display("FAIL write_mosi reg%0d: got %02h/%02h, want %02h/%02h", k, r.mo_a, r.mo_d,
                 {6'b100000, 2'(k)}, wd);
      end
    end
    n_vec++;
    if ({g_dut[0].regs[1], g_dut[0].regs[0]} !== 16'h1234) begin
      n_err++;
      $display("FAIL write_fnddata: got %02h%02h, want 1234", g_dut[0].regs[1], g_dut[0].regs[0]);
    end
  endtask

  task automatic test_read();
    res_t r;
    run_txn(0, 1'b0, 2'd1, 8'h77, 0, 0, r);
    n_vec++;
    if ({r.mo_a, r.mo_d} !== 16'h0100) begin
      n_err++;
      $display("FAIL read_mosi: got %02h/%02h, want 01/00", r.mo_a, r.mo_d);
    end
    n_vec++;
    if (r.n_done !== 1 || r.done_c !== 168 || r.ss_bad !== 0 || r.sclk_bad !== 0 || r.busy_bad !== 0) begin
      n_err++;
      $display("FAIL read_timing: done=%0d@%0d ss_bad=%0d sclk_bad=%0d busy_bad=%0d, want done=1@168 bad=0",
               r.n_done, r.done_c, r.ss_bad, r.sclk_bad, r.busy_bad);
    end
    n_vec++;
    if (r.rd !== 8'h12) begin
      n_err++;
      $display("FAIL read_rdata_at_done: got %02h, want 12", r.rd);
    end
    @(negedge clk);
    n_vec++;
    if (busy_v[0] !== 1'b0 || rdata_v[0] !== 8'h12) begin
      n_err++;
      $display("FAIL read_after_done: busy=%b rdata=%02h, want busy=0 rdata=12", busy_v[0], rdata_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    res_t r;
    run_txn(0, 1'b1, 2'd3, 8'hA5, 0, 0, r);
    n_vec++;
    if (r.n_done !== 1 || r.rd !== 8'h12 || r.ss_bad !== 0) begin
      n_err++;
      $display("FAIL b2b_write: done=%0d rdata=%02h ss_bad=%0d, want done=1 rdata=12 ss_bad=0",
               r.n_done, r.rd, r.ss_bad);
    end
    run_txn(0, 1'b0, 2'd3, 8'h00, 0, 0, r);
    n_vec++;
    if (r.busy0 !== 0 || r.ss0 !== 1) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%0d ss=%0d at start, want busy=0 ss=1", r.busy0, r.ss0);
    end
    n_vec++;
    if (r.rd !== 8'hA5 || r.mo_a !== 8'h03 || r.ss_bad !== 0 || r.sclk_bad !== 0) begin
      n_err++;
      $display("FAIL b2b_read: rdata=%02h mosi_addr=%02h ss_bad=%0d sclk_bad=%0d, want A5/03/0/0",
               r.rd, r.mo_a, r.ss_bad, r.sclk_bad);
    end
  endtask

  task automatic test_busy_ignore();
    res_t r;
    int extra_done, extra_busy;
    run_txn(0, 1'b0, 2'd1, 8'h00, 10, 100, r);
    n_vec++;
    if (r.n_done !== 1 || r.rd !== 8'h12 || r.busy_bad !== 0) begin
      n_err++;
      $display("FAIL ignore_txn: done=%0d rdata=%02h busy_bad=%0d, want done=1 rdata=12 busy_bad=0",
               r.n_done, r.rd, r.busy_bad);
    end
    extra_done = 0;
    extra_busy = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0) extra_done++;
      if (busy_v[0] !== 1'b0) extra_busy++;
    end
    n_vec++;
    if (extra_done !== 0 || extra_busy !== 0 || g_dut[0].regs[0] !== 8'h34) begin
      n_err++;
      $display("FAIL ignore_queued: extra done=%0d busy=%0d reg0=%02h, want 0/0/34",
               extra_done, extra_busy, g_dut[0].regs[0]);
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    @(negedge clk);
    start_v[0] = 1'b1;
    rw_v[0]    = 1'b1;
    addr_v[0]  = 2'd2;
    wdata_v[0] = 8'h77;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    n_vec++;
    if ({ss_v[0], sclk_v[0]} !== 2'b01) begin
      n_err++;
      $display("FAIL abort_pre: ss/sclk got %b%b, want 01", ss_v[0], sclk_v[0]);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({ss_v[0], sclk_v[0], busy_v[0], done_v[0]} !== 4'b1000 || rdata_v[0] !== 8'h00) begin
      n_err++;
      $display("FAIL abort_reset: ss/sclk/busy/done got %b%b%b%b rdata=%02h, want 1000 rdata=00",
               ss_v[0], sclk_v[0], busy_v[0], done_v[0], rdata_v[0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_txn(0, 1'b1, 2'd2, 8'h5A, 0, 0, r);
    n_vec++;
    if (r.n_done !== 1 || r.done_c !== 168 || r.mo_a !== 8'h82 || g_dut[0].regs[2] !== 8'h5A) begin
      n_err++;
      $display("FAIL abort_recover: done=%0d@%0d mosi_addr=%02h reg2=%02h, want 1@168 82 5A",
               r.n_done, r.done_c, r.mo_a, g_dut[0].regs[2]);
    end
    run_txn(0, 1'b0, 2'd2, 8'h00, 0, 0, r);
    n_vec++;
    if (r.rd !== 8'h5A) begin
      n_err++;
      $display("FAIL abort_readback: got %02h, want 5A", r.rd);
    end
  endtask

  task automatic test_sweep();
    res_t r;
    int p;
    logic [1:0] ad_t [3] = '{2'd0, 2'd3, 2'd1};
    logic [7:0] wd_t [3] = '{8'h3C, 8'hC3, 8'h96};
    for (int i = 1; i < 3; i++) begin
      p = pcfg(i);
      for (int k = 0; k < 3; k++) begin
        run_txn(i, 1'b1, ad_t[k], wd_t[k], 0, 0, r);
        n_vec++;
        if (r.n_done !== 1 || r.done_c !== 2 * p || r.ss_bad !== 0 || r.sclk_bad !== 0 ||
            r.mo_d !== wd_t[k]) begin
          n_err++;
          $display("FAIL sweep_write dut%0d: done=%0d@%0d ss_bad=%0d sclk_bad=%0d mosi_data=%02h, want 1@%0d 0 0 %02h",
                   i, r.n_done, r.done_c, r.ss_bad, r.sclk_bad, r.mo_d, 2 * p, wd_t[k]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        run_txn(i, 1'b0, ad_t[k], 8'h00, 0, 0, r);
        n_vec++;
        if (r.rd !== wd_t[k] || r.done_c !== 2 * p || r.ss_bad !== 0 || r.sclk_bad !== 0 ||
            r.busy_bad !== 0) begin
          n_err++;
          $display("FAIL sweep_read dut%0d: rdata=%02h done@%0d ss_bad=%0d sclk_bad=%0d busy_bad=%0d, want %02h @%0d 0 0 0",
                   i, r.rd, r.done_c, r.ss_bad, r.sclk_bad, r.busy_bad, wd_t[k], 2 * p);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
